fp_round_pack: RTL

//   Downstream stage of the magnitude->float converter. Takes the unrounded
//   {exponent, significand, fifth_bit} plus the sign from the sign/magnitude

---
 rtl/fpcvt_pkg.sv | 32 +++
 rtl/fpcvt_round.sv | 44 ++++
 rtl/fp_round_pack.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// ---------------------------------------------------------------------------
// fpcvt_pkg
//   Shared widths, constants and types for the magnitude->float converter.
//   The packed float is {sign, exp[EXP_W-1:0], sig[SIG_W-1:0]}; the
//   unrounded operand adds the first truncated bit (round bit) below sig.
// ---------------------------------------------------------------------------
package fpcvt_pkg;

    localparam int EXP_W = 3;
    localparam int SIG_W = 4;
    localparam int FP_W  = 1 + EXP_W + SIG_W;

    localparam logic [EXP_W-1:0] EXP_MAX    = '1;
    localparam logic [SIG_W-1:0] SIG_MAX    = '1;
    // Significand after a rounding carry: the carry becomes the new leading
    // one and the exponent absorbs the one-bit right shift.
    localparam logic [SIG_W-1:0] SIG_RENORM = {1'b1, {(SIG_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp8_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             fifth;
    } unrounded_t;

endpackage : fpcvt_pkg

// File: rtl/fpcvt_round.sv
// ---------------------------------------------------------------------------
// fpcvt_round
//   Combinational round-half-up of an unrounded float, with renormalisation
//   on significand carry and saturation when the exponent cannot grow.
// Ports
//   op_i   in   unrounded_t   {sign, exp, sig, fifth}
//   fp_o   out  fp8_t         rounded, packed result
//   sat_o  out  1             result was clamped to the largest magnitude
// ---------------------------------------------------------------------------
module fpcvt_round
    import fpcvt_pkg::*;
(
    input  unrounded_t op_i,
    output fp8_t       fp_o,
    output logic       sat_o
);

    // One extra bit catches the carry out of the significand.
    logic [SIG_W:0] sig_r;
    assign sig_r = {1'b0, op_i.sig} + {{SIG_W{1'b0}}, op_i.fifth};

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        fp_o.sign = op_i.sign;
        fp_o.exp  = op_i.exp;
        fp_o.sig  = sig_r[SIG_W-1:0];
        sat_o     = 1'b0;

        if (sig_r[SIG_W]) begin
            if (op_i.exp == EXP_MAX) begin
                fp_o.exp = EXP_MAX;
                fp_o.sig = SIG_MAX;
                sat_o    = 1'b1;
            end else begin
                fp_o.exp = op_i.exp + {{(EXP_W-1){1'b0}}, 1'b1};
                fp_o.sig = SIG_RENORM;
            end
        end
        // exp=MAX, sig=all-ones without a round bit is an out-of-domain
        // operand; it simply passes through above with sat_o=0.
    end

endmodule : fpcvt_round

// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack
//   Rounds and packs the unrounded converter result into an 8-bit float
//   through a two-register valid/ready pipeline (2-cycle latency, one result
//   per cycle, full-throughput backpressure with a combinational ready chain).
//   Optional saturation reporting is enabled by defining FPCVT_SAT_CNT_EN.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      upstream operand valid
//   in_ready   out  1      operand accepted this cycle when in_valid
//   in_sign    in   1      sign of the original input
//   in_exp     in   EXP_W  unrounded exponent
//   in_sig     in   SIG_W  unrounded significand
//   in_fifth   in   1      round bit
//   out_valid  out  1      out_fp holds a result
//   out_ready  in   1      downstream consumes the result this cycle
//   out_fp     out  8      packed {sign, exp, sig}
//   out_sat    out  1      [FPCVT_SAT_CNT_EN] result was saturated
//   sat_count  out  CNT_W  [FPCVT_SAT_CNT_EN] saturating beats delivered
//   sat_clr    in   1      [FPCVT_SAT_CNT_EN] synchronous counter clear
// ---------------------------------------------------------------------------
module fp_round_pack
    import fpcvt_pkg::*;
`ifdef FPCVT_SAT_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    input  logic             in_fifth,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_fp
`ifdef FPCVT_SAT_CNT_EN
   ,output logic             out_sat,
    output logic [CNT_W-1:0] sat_count,
    input  logic             sat_clr
`endif
);

    // -----------------------------------------------------------------------
    // Rounding ahead of the stage-1 register
    // -----------------------------------------------------------------------
    unrounded_t rnd_in;
    fp8_t       rnd_fp;
    logic       rnd_sat;

    assign rnd_in = '{sign: in_sign, exp: in_exp, sig: in_sig, fifth: in_fifth};

    fpcvt_round u_round (
        .op_i  (rnd_in),
        .fp_o  (rnd_fp),
        .sat_o (rnd_sat)
    );

    // -----------------------------------------------------------------------
    // Pipeline registers and ready chain
    // -----------------------------------------------------------------------
    logic s1_valid_q;
    fp8_t s1_fp_q;
    logic s2_valid_q;
    fp8_t s2_fp_q;
    logic s1_adv;

    // Stage 2 can take a new word when empty or being drained this cycle;
    // stage 1 likewise when empty or moving into stage 2.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values. Data registers are reset as well because the
    // packed output is architecturally visible as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fp_q    <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_fp_q <= rnd_fp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_fp_q    <= '0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_fp_q <= s1_fp_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_fp    = s2_fp_q;

`ifdef FPCVT_SAT_CNT_EN
    // -----------------------------------------------------------------------
    // Saturation flag travels alongside the data; counter of delivered
    // saturating beats, sticky at all-ones, clear has priority.
    // -----------------------------------------------------------------------
    logic             s1_sat_q;
    logic             s2_sat_q;
    logic [CNT_W-1:0] sat_count_q;
    logic [CNT_W-1:0] sat_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sat_q <= 1'b0;
        end else if (in_ready && in_valid) begin
            s1_sat_q <= rnd_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sat_q <= 1'b0;
        end else if (s1_adv && s1_valid_q) begin
            s2_sat_q <= s1_sat_q;
        end
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && out_ready && s2_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign out_sat   = s2_sat_q;
    assign sat_count = sat_count_q;
`else
    // Saturation is still detected by the rounder but not reported.
    logic unused_sat;
    assign unused_sat = rnd_sat;
`endif

endmodule : fp_round_pack
